rxll_frame: RTL and testbench

RXLL_FRAME -- requirements
Module: rxll_frame

---
 rtl/rxll_frame.sv | 239 +++++++++++++++++++++++
 tb/tb_rxll_frame.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxll_frame.sv
// SATA receive framer: delays the link-layer stream by one dword so the trailing CRC dword
// is stripped, then buffers beats in a FIFO for the trn_* interface. Define RXLL_FRAME_CRC_EN to add the CRC check.
module rxll_frame #(
    parameter int C_DEPTH    = 32,
    parameter int C_HOLD_THR = 16
) (
    input  logic        phyclk,
    input  logic        phyreset_n,
    input  logic [31:0] rx_dat,
    input  logic        rx_vld,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic        rx_hold,
    output logic [31:0] trn_rd,
    output logic        trn_rsof_n,
    output logic        trn_reof_n,
    output logic        trn_rsrc_rdy_n,
    output logic        trn_rsrc_dsc_n,
    input  logic        trn_rdst_rdy_n,
    output logic        crc_err,
    output logic        runt_err,
    output logic        ovf_err
);
    localparam int AW = $clog2(C_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(C_DEPTH);
    localparam logic [AW:0] HOLD_C  = (AW+1)'(C_HOLD_THR);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    typedef struct packed {
        logic [31:0] dat;
        logic        sof;
        logic        eof;
        logic        dsc_n;
    } entry_t;

    state_t      state_r, state_nxt_s;
    logic        pend_vld_r, pend_first_r, bad_r;
    logic [31:0] pend_dat_r;
    logic        pend_vld_nxt_s, pend_first_nxt_s, load_pend_s;
    logic        push_s, runt_s, crc_mis_s;
    entry_t      push_ent_s;

    logic [AW:0]   occ_r, occ_nxt_s;
    logic [AW-1:0] wptr_r, rptr_r;
    entry_t        mem_r [C_DEPTH];
    entry_t        out_r;
    logic          out_vld_r, rx_hold_r, runt_err_r, ovf_err_r;
    logic          pop_s, push_ok_s, load_s, mem_empty_s, mem_we_s;

    // Frame decode: decides what the pending register does with the incoming dword
    always_comb begin
        state_nxt_s      = state_r;
        pend_vld_nxt_s   = pend_vld_r;
        pend_first_nxt_s = pend_first_r;
        load_pend_s      = 1'b0;
        push_s           = 1'b0;
        runt_s           = 1'b0;
        push_ent_s.dat   = pend_dat_r;
        push_ent_s.sof   = pend_first_r;
        push_ent_s.eof   = 1'b0;
        push_ent_s.dsc_n = 1'b1;
        if (rx_vld) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_sof && rx_eof) begin
                        runt_s = 1'b1;
                    end else if (rx_sof) begin
                        load_pend_s      = 1'b1;
                        pend_first_nxt_s = 1'b1;
                        pend_vld_nxt_s   = 1'b1;
                        state_nxt_s      = ST_RUN;
                    end else begin
                        pend_vld_nxt_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rx_sof) begin
                        // a new SOF cuts the running frame short and marks it bad
                        push_s           = pend_vld_r;
                        push_ent_s.eof   = 1'b1;
                        push_ent_s.dsc_n = 1'b0;
                        if (rx_eof) begin
                            runt_s         = 1'b1;
                            pend_vld_nxt_s = 1'b0;
                            state_nxt_s    = ST_IDLE;
                        end else begin
                            load_pend_s      = 1'b1;
                            pend_first_nxt_s = 1'b1;
                            pend_vld_nxt_s   = 1'b1;
                        end
                    end else if (rx_eof) begin
                        if (pend_vld_r) begin
                            push_s           = 1'b1;
                            push_ent_s.eof   = 1'b1;
                            push_ent_s.dsc_n = ~(bad_r | crc_mis_s);
                        end else begin
                            runt_s = 1'b1;
                        end
                        pend_vld_nxt_s = 1'b0;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        push_s           = pend_vld_r;
                        load_pend_s      = 1'b1;
                        pend_first_nxt_s = 1'b0;
                        pend_vld_nxt_s   = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    pend_vld_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign pop_s       = out_vld_r & ~trn_rdst_rdy_n;
    assign push_ok_s   = push_s & ((occ_r != DEPTH_C) | pop_s);
    assign load_s      = ~out_vld_r | pop_s;
    assign mem_empty_s = (occ_r == {{AW{1'b0}}, out_vld_r});
    assign mem_we_s    = push_ok_s & ~(load_s & mem_empty_s) & phyreset_n;
    assign occ_nxt_s   = occ_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_s};

    // Frame state, pending dword, sticky frame-bad flag and error pulses
    always_ff @(posedge phyclk) begin
        if (!phyreset_n) begin
            state_r      <= ST_IDLE;
            pend_vld_r   <= 1'b0;
            pend_first_r <= 1'b0;
            pend_dat_r   <= 32'h0000_0000;
            bad_r        <= 1'b0;
            runt_err_r   <= 1'b0;
            ovf_err_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pend_vld_r <= pend_vld_nxt_s;
            if (load_pend_s) begin
                pend_dat_r   <= rx_dat;
                pend_first_r <= pend_first_nxt_s;
            end
            if (push_s && !push_ok_s) begin
                bad_r <= 1'b1;
            end else if (push_ok_s && push_ent_s.eof) begin
                bad_r <= 1'b0;
            end
            runt_err_r <= runt_s;
            ovf_err_r  <= push_s & ~push_ok_s;
        end
    end

    // FIFO storage; the head entry lives in out_r, so mem_r never holds more than C_DEPTH-1
    always_ff @(posedge phyclk) begin
        if (mem_we_s) begin
            mem_r[wptr_r] <= push_ent_s;
        end
    end

    // FIFO pointers, occupancy and the registered output beat
    always_ff @(posedge phyclk) begin
        if (!phyreset_n) begin
            occ_r     <= '0;
            wptr_r    <= '0;
            rptr_r    <= '0;
            out_vld_r <= 1'b0;
            out_r     <= '{dat: 32'h0000_0000, sof: 1'b0, eof: 1'b0, dsc_n: 1'b1};
            rx_hold_r <= 1'b0;
        end else begin
            occ_r     <= occ_nxt_s;
            rx_hold_r <= (occ_nxt_s >= HOLD_C);
            if (mem_we_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (load_s) begin
                if (!mem_empty_s) begin
                    out_r     <= mem_r[rptr_r];
                    rptr_r    <= rptr_r + AW'(1);
                    out_vld_r <= 1'b1;
                end else if (push_ok_s) begin
                    out_r     <= push_ent_s;
                    out_vld_r <= 1'b1;
                end else begin
                    out_vld_r   <= 1'b0;
                    out_r.sof   <= 1'b0;
                    out_r.eof   <= 1'b0;
                    out_r.dsc_n <= 1'b1;
                end
            end
        end
    end

`ifdef RXLL_FRAME_CRC_EN
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_SEED = 32'h5232_5032;

    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] dat);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ dat[i];
            c  = fb ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    logic [31:0] crc_r;
    logic        crc_err_r;

    assign crc_mis_s = (crc_r != rx_dat);

    // Running CRC over every frame dword that enters the pending register
    always_ff @(posedge phyclk) begin
        if (!phyreset_n) begin
            crc_r     <= CRC_SEED;
            crc_err_r <= 1'b0;
        end else begin
            if (load_pend_s) begin
                crc_r <= crc32_step(pend_first_nxt_s ? CRC_SEED : crc_r, rx_dat);
            end
            crc_err_r <= rx_vld & (state_r == ST_RUN) & ~rx_sof & rx_eof & pend_vld_r & crc_mis_s;
        end
    end

    assign crc_err = crc_err_r;
`else
    assign crc_mis_s = 1'b0;
    assign crc_err   = 1'b0;
`endif

    assign rx_hold        = rx_hold_r;
    assign trn_rd         = out_r.dat;
    assign trn_rsof_n     = ~out_r.sof;
    assign trn_reof_n     = ~out_r.eof;
    assign trn_rsrc_dsc_n = out_r.dsc_n;
    assign trn_rsrc_rdy_n = ~out_vld_r;
    assign runt_err       = runt_err_r;
    assign ovf_err        = ovf_err_r;
endmodule

// File: tb/tb_rxll_frame.sv
// Scoreboard bench for rxll_frame: a frame-level reference model queues expected beats,
// a negedge monitor pops and compares them along with occupancy, hold and error pulses.
module tb_rxll_frame;
    localparam int DEPTH = 32;
    localparam int THR   = 16;
`ifdef RXLL_FRAME_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'h5232_5032;

    logic        phyclk = 1'b0;
    logic        phyreset_n, rx_vld, rx_sof, rx_eof, trn_rdst_rdy_n;
    logic [31:0] rx_dat, trn_rd;
    logic        rx_hold, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n;
    logic        crc_err, runt_err, ovf_err;

    rxll_frame #(.C_DEPTH(DEPTH), .C_HOLD_THR(THR)) dut (
        .phyclk(phyclk), .phyreset_n(phyreset_n), .rx_dat(rx_dat), .rx_vld(rx_vld),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_hold(rx_hold), .trn_rd(trn_rd),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
        .crc_err(crc_err), .runt_err(runt_err), .ovf_err(ovf_err));

    always #5 phyclk = ~phyclk;

    typedef struct {
        logic [31:0] dat;
        logic        sof;
        logic        eof;
        logic        dsc_n;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    bit          rnd_dst = 1'b0;

    // reference model state
    bit          m_in_frame = 1'b0, m_pend_vld = 1'b0, m_pend_first = 1'b0, m_bad = 1'b0, m_pop = 1'b0;
    logic [31:0] m_pend_dat, m_crc;
    int          m_occ = 0;
    int          m_acc = 0;
    bit          exp_runt = 1'b0, exp_ovf = 1'b0, exp_crc = 1'b0;

    function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_push(input logic [31:0] d, input bit s, input bit e, input bit dn);
        if (m_occ - int'(m_pop) < DEPTH) begin
            exp_q.push_back('{d, s, e, dn});
            m_acc = 1;
            if (e) m_bad = 1'b0;
        end else begin
            exp_ovf = 1'b1;
            m_bad   = 1'b1;
        end
    endtask

    // Applies the framing rules to the inputs present at this clock edge
    task automatic model_edge();
        bit bad_crc;
        exp_runt = 1'b0; exp_ovf = 1'b0; exp_crc = 1'b0; m_acc = 0;
        if (!phyreset_n) begin
            exp_q.delete();
            m_occ = 0; m_in_frame = 1'b0; m_pend_vld = 1'b0; m_bad = 1'b0;
            return;
        end
        m_pop = (m_occ > 0) && !trn_rdst_rdy_n;
        if (rx_vld) begin
            if (rx_sof) begin
                if (m_in_frame) m_push(m_pend_dat, m_pend_first, 1'b1, 1'b0);
                if (rx_eof) begin
                    exp_runt = 1'b1; m_in_frame = 1'b0; m_pend_vld = 1'b0;
                end else begin
                    m_in_frame = 1'b1; m_pend_vld = 1'b1; m_pend_first = 1'b1;
                    m_pend_dat = rx_dat; m_crc = crc_fold(SEED, rx_dat);
                end
            end else if (m_in_frame) begin
                if (rx_eof) begin
                    if (m_pend_vld) begin
                        bad_crc = CRC_EN && (m_crc != rx_dat);
                        exp_crc = bad_crc;
                        m_push(m_pend_dat, m_pend_first, 1'b1, !(m_bad || bad_crc));
                    end else begin
                        exp_runt = 1'b1;
                    end
                    m_in_frame = 1'b0; m_pend_vld = 1'b0;
                end else begin
                    if (m_pend_vld) m_push(m_pend_dat, m_pend_first, 1'b0, 1'b1);
                    m_pend_dat = rx_dat; m_pend_first = 1'b0; m_crc = crc_fold(m_crc, rx_dat);
                end
            end
        end
        m_occ = m_occ - int'(m_pop) + m_acc;
    endtask

    task automatic cyc();
        @(posedge phyclk);
        model_edge();
        #1;
        if (rnd_dst) trn_rdst_rdy_n = ($urandom_range(0, 2) == 0);
    endtask

    task automatic drv(input bit v, input bit s, input bit e, input logic [31:0] d);
        rx_vld = v; rx_sof = s; rx_eof = e; rx_dat = d;
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic send_frame(input logic [31:0] words[$], input bit corrupt, input bit gaps, input bit no_eof);
        logic [31:0] c;
        c = SEED;
        for (int i = 0; i < words.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle(1);
            drv(1'b1, i == 0, 1'b0, words[i]);
            c = crc_fold(c, words[i]);
        end
        if (!no_eof) drv(1'b1, 1'b0, 1'b1, corrupt ? (c ^ 32'h0000_0001) : c);
    endtask

    task automatic check_reset_outs(input string tag);
        chk_w({tag, "_rd"}, trn_rd, 32'h0000_0000);
        chk_b({tag, "_rdy_n"}, trn_rsrc_rdy_n, 1'b1);
        chk_b({tag, "_sof_n"}, trn_rsof_n, 1'b1);
        chk_b({tag, "_eof_n"}, trn_reof_n, 1'b1);
        chk_b({tag, "_dsc_n"}, trn_rsrc_dsc_n, 1'b1);
        chk_b({tag, "_hold"}, rx_hold, 1'b0);
        chk_b({tag, "_errs"}, crc_err | runt_err | ovf_err, 1'b0);
    endtask

    // Monitor: per-cycle status checks and scoreboard pop on every transferring beat
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rd;
    logic [2:0]  prev_mk;
    beat_t       e;
    always @(negedge phyclk) begin
        if (mon_en) begin
            chk_b("valid", trn_rsrc_rdy_n, m_occ == 0);
            chk_b("rx_hold", rx_hold, m_occ >= THR);
            chk_b("runt_err", runt_err, exp_runt);
            chk_b("ovf_err", ovf_err, exp_ovf);
            chk_b("crc_err", crc_err, exp_crc);
            if (prev_stall) begin
                chk_w("stable_rd", trn_rd, prev_rd);
                chk_w("stable_mk", {29'd0, trn_rsof_n, trn_reof_n, trn_rsrc_dsc_n}, {29'd0, prev_mk});
            end
            prev_stall <= phyreset_n && !trn_rsrc_rdy_n && trn_rdst_rdy_n;
            prev_rd    <= trn_rd;
            prev_mk    <= {trn_rsof_n, trn_reof_n, trn_rsrc_dsc_n};
            if (phyreset_n && !trn_rsrc_rdy_n && !trn_rdst_rdy_n) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat: unexpected beat %h, none expected at %0t", trn_rd, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk_w("beat_dat", trn_rd, e.dat);
                    chk_b("beat_sof", !trn_rsof_n, e.sof);
                    chk_b("beat_eof", !trn_reof_n, e.eof);
                    if (e.eof) chk_b("beat_dsc_n", trn_rsrc_dsc_n, e.dsc_n);
                end
            end
        end
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] c;
        int          k;
        phyreset_n = 1'b0; rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        rx_dat = 32'h0; trn_rdst_rdy_n = 1'b0;
        cyc(); cyc();
        check_reset_outs("reset");
        mon_en = 1'b1;
        phyreset_n = 1'b1;
        idle(2);

        // good three-dword frame, then the same frame with a corrupted CRC dword
        w = '{32'h0000_0046, 32'hA5A5_A5A5, 32'h1122_3344};
        send_frame(w, 1'b0, 1'b0, 1'b0); idle(4);
        send_frame(w, 1'b1, 1'b0, 1'b0); idle(4);

        // runt then a one-data-dword frame
        drv(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        w = '{32'hCAFE_0001};
        send_frame(w, 1'b0, 1'b0, 1'b0); idle(4);

        // 40 dwords into a stalled sink, release, then close the frame
        trn_rdst_rdy_n = 1'b1;
        c = SEED;
        for (int i = 0; i < 40; i++) begin
            drv(1'b1, i == 0, 1'b0, 32'h1000_0000 + 32'(i));
            c = crc_fold(c, 32'h1000_0000 + 32'(i));
        end
        trn_rdst_rdy_n = 1'b0;
        idle(12);
        drv(1'b1, 1'b0, 1'b1, c);
        for (int i = 0; i < 100 && m_occ > 0; i++) idle(1);

        // reset in the middle of a frame, stray dword, then a fresh frame
        for (int i = 0; i < 5; i++) drv(1'b1, i == 0, 1'b0, 32'h2000_0000 + 32'(i));
        phyreset_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 32'h0);
        phyreset_n = 1'b1;
        check_reset_outs("midrst");
        drv(1'b1, 1'b0, 1'b0, 32'h5555_0000);
        w = '{32'h3000_0001, 32'h3000_0002, 32'h3000_0003};
        send_frame(w, 1'b0, 1'b0, 1'b0); idle(4);

        // frame cut short by a new SOF
        w = '{32'h4000_0001, 32'h4000_0002};
        send_frame(w, 1'b0, 1'b0, 1'b1);
        w = '{32'h4100_0001, 32'h4100_0002, 32'h4100_0003};
        send_frame(w, 1'b0, 1'b0, 1'b0); idle(4);

        // randomized traffic with a randomly stalling sink
        rnd_dst = 1'b1;
        for (int f = 0; f < 150; f++) begin
            idle($urandom_range(0, 2));
            k = $urandom_range(0, 9);
            if (k == 0) begin
                drv(1'b1, 1'b1, 1'b1, $urandom);
            end else if (k == 1) begin
                drv(1'b1, 1'b0, 1'b0, $urandom);
            end else begin
                w.delete();
                for (int i = 0; i < $urandom_range(1, 6); i++) w.push_back($urandom);
                send_frame(w, $urandom_range(0, 3) == 0, 1'b1, k == 2);
            end
        end
        // close any frame left open, then drain
        drv(1'b1, 1'b0, 1'b1, $urandom);
        rnd_dst = 1'b0;
        trn_rdst_rdy_n = 1'b0;
        for (int i = 0; i < 200 && m_occ > 0; i++) idle(1);
        chk_b("drain_timeout", m_occ == 0, 1'b1);
        idle(2);
        chk_w("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
